vid_pattern_src: RTL and testbench

Streaming video test-pattern source. It drives the pixel-stream interface consumed by the vision filter chain (`valid`, `packet_video`, r/g/b, x/y), adding `ready` backpressure and start/end-of-packet markers. Each frame is one non-video control beat followed by a WIDTH×HEIGHT video packet. It sits at the head of the pipeline in place of the camera path, so filters and detectors can be exercised with deterministic images.

---
 rtl/vid_pattern_src.sv | 216 +++++++++++++++++++++
 tb/tb_vid_pattern_src.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vid_pattern_src.sv
// Streaming video test-pattern source: per frame one control beat, then a WIDTH x HEIGHT
// video packet with sop/eop markers, then GAP_CYCLES idle cycles. All outputs registered.
module vid_pattern_src #(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic        ready,
    output logic        valid,
    output logic        packet_video,
    output logic        sop,
    output logic        eop,
    output logic [7:0]  r_out,
    output logic [7:0]  g_out,
    output logic [7:0]  b_out,
    output logic [10:0] x_out,
    output logic [10:0] y_out
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [10:0] XLast   = 11'(WIDTH - 1);
    localparam logic [10:0] YLast   = 11'(HEIGHT - 1);
    localparam logic [10:0] BarLast = 11'(WIDTH / 8 - 1);

    typedef enum logic [1:0] {StIdle, StCtrl, StVideo, StGap} state_e;

    state_e          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [7:0]      frame_q, frame_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [10:0]     bar_pos_q, bar_pos_d;
    logic [2:0]      bar_idx_q, bar_idx_d;
    logic            valid_q, valid_d;
    logic            pv_q, pv_d;
    logic            sop_q, sop_d;
    logic            eop_q, eop_d;
    logic [23:0]     rgb_q, rgb_d;
    logic [10:0]     x_q, x_d;
    logic [10:0]     y_q, y_d;

    logic [10:0]     nx, ny, npos;
    logic [2:0]      nidx;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    function automatic logic [23:0] pattern(input logic [1:0]  m,
                                            input logic [10:0] px,
                                            input logic [10:0] py,
                                            input logic [2:0]  bar,
                                            input logic [7:0]  fc);
        logic [23:0] c;
        case (m)
            2'd0:    c = bar_colour(bar);
            2'd1:    c = {3{px[7:0]}};
            2'd2:    c = (px[4] ^ py[4]) ? 24'hFFFFFF : 24'h000000;
            default: c = {fc, 8'h00, ~fc};
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_q    <= 2'd0;
            frame_q   <= 8'd0;
            gap_q     <= '0;
            bar_pos_q <= 11'd0;
            bar_idx_q <= 3'd0;
            valid_q   <= 1'b0;
            pv_q      <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            rgb_q     <= 24'd0;
            x_q       <= 11'd0;
            y_q       <= 11'd0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            frame_q   <= frame_d;
            gap_q     <= gap_d;
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
            valid_q   <= valid_d;
            pv_q      <= pv_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            rgb_q     <= rgb_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        gap_d   = gap_q;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StCtrl;
                    mode_d  = mode;
                end
            end
            StCtrl: begin
                if (ready) state_d = StVideo;
            end
            StVideo: begin
                if (ready && eop_q) begin
                    state_d = StGap;
                    gap_d   = '0;
                end
            end
            default: begin
                if (gap_q == GapLast) begin
                    state_d = enable ? StCtrl : StIdle;
                    if (enable) mode_d = mode;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
        endcase
    end

    // Next pixel position; the bar index follows a line-local counter instead of x / (WIDTH/8).
    always_comb begin
        nx   = 11'd0;
        ny   = 11'd0;
        npos = 11'd0;
        nidx = 3'd0;
        if (state_q == StVideo) begin
            if (x_q == XLast) begin
                ny = y_q + 11'd1;
            end else begin
                nx = x_q + 11'd1;
                ny = y_q;
                if (bar_pos_q == BarLast) begin
                    nidx = bar_idx_q + 3'd1;
                end else begin
                    npos = bar_pos_q + 11'd1;
                    nidx = bar_idx_q;
                end
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        pv_d      = pv_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        rgb_d     = rgb_q;
        x_d       = x_q;
        y_d       = y_q;
        bar_pos_d = bar_pos_q;
        bar_idx_d = bar_idx_q;
        frame_d   = frame_q;
        if (ready && (state_q == StCtrl || (state_q == StVideo && !eop_q))) begin
            valid_d   = 1'b1;
            pv_d      = 1'b1;
            sop_d     = (nx == 11'd0) && (ny == 11'd0);
            eop_d     = (nx == XLast) && (ny == YLast);
            rgb_d     = pattern(mode_q, nx, ny, nidx, frame_q);
            x_d       = nx;
            y_d       = ny;
            bar_pos_d = npos;
            bar_idx_d = nidx;
        end else if (ready && state_q == StVideo) begin
            valid_d = 1'b0;
            pv_d    = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            rgb_d   = 24'd0;
            x_d     = 11'd0;
            y_d     = 11'd0;
            frame_d = frame_q + 8'd1;
        end
        if (state_q != StCtrl && state_d == StCtrl) begin
            valid_d = 1'b1;
            pv_d    = 1'b0;
            sop_d   = 1'b1;
            eop_d   = 1'b1;
            rgb_d   = 24'h00000F;
            x_d     = 11'd0;
            y_d     = 11'd0;
        end
    end

    assign valid        = valid_q;
    assign packet_video = pv_q;
    assign sop          = sop_q;
    assign eop          = eop_q;
    assign r_out        = rgb_q[23:16];
    assign g_out        = rgb_q[15:8];
    assign b_out        = rgb_q[7:0];
    assign x_out        = x_q;
    assign y_out        = y_q;

endmodule

// File: tb/tb_vid_pattern_src.sv
// Directed bench for vid_pattern_src at 16x4 with a 2-cycle gap; expected beats come
// from hand-derived pattern rules, checked by immediate assertions.
module tb_vid_pattern_src;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd1;
    logic        ready = 1'b1;
    logic        valid, packet_video, sop, eop;
    logic [7:0]  r_out, g_out, b_out;
    logic [10:0] x_out, y_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    vid_pattern_src #(
        .WIDTH(16),
        .HEIGHT(4),
        .GAP_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .mode(mode),
        .ready(ready),
        .valid(valid),
        .packet_video(packet_video),
        .sop(sop),
        .eop(eop),
        .r_out(r_out),
        .g_out(g_out),
        .b_out(b_out),
        .x_out(x_out),
        .y_out(y_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obs_beat();
        return 64'({valid, packet_video, sop, eop, r_out, g_out, b_out, x_out, y_out});
    endfunction

    function automatic logic [63:0] exp_beat(input logic v, input logic pv, input logic s,
                                             input logic e, input logic [23:0] rgb,
                                             input int x, input int y);
        return 64'({v, pv, s, e, rgb, 11'(x), 11'(y)});
    endfunction

    // Bars are 2 pixels wide at WIDTH=16.
    function automatic logic [23:0] exp_rgb(input logic [1:0] m, input int x, input int y,
                                            input logic [7:0] fc);
        logic [23:0] c;
        case (m)
            2'd0: begin
                case (x / 2)
                    0:       c = 24'hFFFFFF;
                    1:       c = 24'hFFFF00;
                    2:       c = 24'h00FFFF;
                    3:       c = 24'h00FF00;
                    4:       c = 24'hFF00FF;
                    5:       c = 24'hFF0000;
                    6:       c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            2'd1:    c = {3{8'(x)}};
            2'd2:    c = ((((x ^ y) >> 4) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: c = {fc, 8'h00, ~fc};
        endcase
        return c;
    endfunction

    // Starts with the control beat presented; ends with the eop beat presented.
    task automatic run_frame(input logic [1:0] m, input logic [7:0] fc,
                             input int stall_at, input int stall_len,
                             input int chg_at, input logic [1:0] chg_mode, input logic chg_en,
                             output int eop_lat);
        int t0;
        logic [63:0] e;
        check("ctrl", obs_beat(), exp_beat(1'b1, 1'b0, 1'b1, 1'b1, 24'h00000F, 0, 0));
        t0 = cyc;
        eop_lat = 0;
        for (int p = 0; p < 64; p++) begin
            step();
            e = exp_beat(1'b1, 1'b1, p == 0, p == 63, exp_rgb(m, p % 16, p / 16, fc),
                         p % 16, p / 16);
            check($sformatf("pix m%0d p%0d", m, p), obs_beat(), e);
            if (p == 63) eop_lat = cyc - t0;
            if (p == chg_at) begin
                mode = chg_mode;
                enable = chg_en;
            end
            if (p == stall_at) begin
                ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    check($sformatf("stall p%0d s%0d", p, s), obs_beat(), e);
                end
                ready = 1'b1;
            end
        end
    endtask

    task automatic gap_check(input logic expect_ctrl);
        step();
        check("gap0", 64'(valid), 64'd0);
        step();
        check("gap1", 64'(valid), 64'd0);
        step();
        check("after_gap_valid", 64'(valid), 64'(expect_ctrl));
    endtask

    initial begin
        int lat0, lat1, lat_x, t_start;

        // Reset state.
        #2 rst = 1'b1;
        #1;
        check("rst_async", obs_beat(), 64'd0);
        step();
        step();
        check("rst_hold", obs_beat(), 64'd0);
        rst = 1'b0;
        step();
        check("idle_no_enable", 64'(valid), 64'd0);

        // Free-running grey ramp frame and frame period.
        enable = 1'b1;
        mode = 2'd1;
        step();
        t_start = cyc;
        run_frame(2'd1, 8'd0, -1, 0, -1, 2'd1, 1'b1, lat0);
        gap_check(1'b1);
        check("period", 64'(cyc - t_start), 64'd67);

        // Backpressure at (5,1).
        run_frame(2'd1, 8'd1, 21, 3, -1, 2'd1, 1'b1, lat1);
        check("eop_shift", 64'(lat1 - lat0), 64'd3);
        check("lat0", 64'(lat0), 64'd64);
        mode = 2'd0;
        gap_check(1'b1);

        // Colour bars.
        run_frame(2'd0, 8'd2, -1, 0, -1, 2'd0, 1'b1, lat_x);
        mode = 2'd2;
        gap_check(1'b1);

        // Checkerboard with a mid-frame mode change that must wait for the next frame.
        run_frame(2'd2, 8'd3, -1, 0, 10, 2'd0, 1'b1, lat_x);
        gap_check(1'b1);
        run_frame(2'd0, 8'd4, -1, 0, -1, 2'd0, 1'b1, lat_x);
        mode = 2'd3;
        gap_check(1'b1);

        // Frame-count solid interrupted by reset at (7,2).
        check("ctrl_pre_rst", obs_beat(), exp_beat(1'b1, 1'b0, 1'b1, 1'b1, 24'h00000F, 0, 0));
        for (int p = 0; p < 40; p++) step();
        check("pix_7_2", obs_beat(), exp_beat(1'b1, 1'b1, 1'b0, 1'b0, 24'h0500FA, 7, 2));
        rst = 1'b1;
        #1;
        check("rst_midframe", obs_beat(), 64'd0);
        step();
        check("rst_midframe_hold", obs_beat(), 64'd0);
        rst = 1'b0;
        enable = 1'b0;
        step();
        check("idle_after_rst", 64'(valid), 64'd0);
        enable = 1'b1;
        step();

        // Three consecutive frame-count frames from a freshly reset counter.
        run_frame(2'd3, 8'd0, -1, 0, -1, 2'd3, 1'b1, lat_x);
        gap_check(1'b1);
        run_frame(2'd3, 8'd1, -1, 0, -1, 2'd3, 1'b1, lat_x);
        gap_check(1'b1);
        // Enable drops mid-frame: frame completes, then gap, then idle.
        run_frame(2'd3, 8'd2, -1, 0, 30, 2'd3, 1'b0, lat_x);
        gap_check(1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("idle_tail%0d", i), 64'(valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
